// File: rtl/instr_queue_if.sv
// Handshake bundle between the bus unit / decoder and the instruction byte queue.
// The master side drives fetch words and pops; the slave side is the queue itself.
interface instr_queue_if #(parameter int DEPTH = 8);
  logic                   iFlush;
  logic [15:0]            iFlushIP;
  logic                   iWrValid;
  logic [15:0]            iWrData;
  logic                   iWrOdd;
  logic                   oWrReady;
  logic [47:0]            oWin;
  logic [$clog2(DEPTH):0] oCount;
  logic                   iPop;
  logic [2:0]             iPopLen;
  logic                   oPopErr;
  logic [15:0]            oIP;

  modport master (
    output iFlush, iFlushIP, iWrValid, iWrData, iWrOdd, iPop, iPopLen,
    input  oWrReady, oWin, oCount, oPopErr, oIP
  );

  modport slave (
    input  iFlush, iFlushIP, iWrValid, iWrData, iWrOdd, iPop, iPopLen,
    output oWrReady, oWin, oCount, oPopErr, oIP
  );
endinterface

// File: rtl/instr_queue.sv
// Prefetch byte queue: circular byte store fed by 16-bit fetch words, presenting a
// six-byte head window to the length decoder and retiring decoded lengths.
module instr_queue #(
  parameter int DEPTH = 8
) (
  input logic          iClk,
  input logic          iRst,
  instr_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    store [DEPTH];
  logic [AW-1:0] rdPtr;
  logic [AW-1:0] wrPtr;
  logic [CW-1:0] count;
  logic [15:0]   ip;
  logic          popErr;

  logic          pushTake;
  logic          popLegal;
  logic          popBad;
  logic [CW-1:0] pushLen;
  logic [CW-1:0] popLen;

  always_comb begin
    pushLen  = q.iWrOdd ? CW'(1) : CW'(2);
    popLen   = CW'(q.iPopLen);
    pushTake = q.iWrValid && q.oWrReady;
    popLegal = q.iPop && (q.iPopLen != 3'd0) && (popLen <= count);
    popBad   = q.iPop && !popLegal;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      rdPtr  <= '0;
      wrPtr  <= '0;
      count  <= '0;
      ip     <= 16'h0000;
      popErr <= 1'b0;
      for (int i = 0; i < DEPTH; i++) store[i] <= 8'h00;
    end else if (q.iFlush) begin
      // Flush wins over any concurrent push or pop and never reports a pop error.
      rdPtr  <= '0;
      wrPtr  <= '0;
      count  <= '0;
      ip     <= q.iFlushIP;
      popErr <= 1'b0;
    end else begin
      popErr <= popBad;
      if (pushTake) begin
        if (q.iWrOdd) begin
          store[wrPtr] <= q.iWrData[15:8];
        end else begin
          store[wrPtr]            <= q.iWrData[7:0];
          store[wrPtr + AW'(1)]   <= q.iWrData[15:8];
        end
        wrPtr <= wrPtr + AW'(pushLen);
      end
      if (popLegal) begin
        rdPtr <= rdPtr + AW'(q.iPopLen);
        ip    <= ip + 16'(q.iPopLen);
      end
      count <= count - (popLegal ? popLen : '0) + (pushTake ? pushLen : '0);
    end
  end

  // Window wraps through the store by plain pointer overflow.
  always_comb begin
    q.oWin = '0;
    for (int k = 0; k < 6; k++) q.oWin[k*8 +: 8] = store[rdPtr + AW'(k)];
  end

  assign q.oWrReady = (count <= CW'(DEPTH - 2));
  assign q.oCount   = count;
  assign q.oIP      = ip;
  assign q.oPopErr  = popErr;
endmodule

// File: tb/tb_instr_queue.sv
// Bench for instr_queue: table of stimulus/expectation records run through a
// scoreboard queue, plus a hand-written asynchronous reset sequence.
module tb_instr_queue;
  typedef struct packed {
    logic        flush;
    logic [15:0] fip;
    logic        wv;
    logic [15:0] wd;
    logic        wo;
    logic        pop;
    logic [2:0]  pl;
    logic [3:0]  eCount;
    logic [15:0] eIP;
    logic        eErr;
    logic        eRdy;
    logic [47:0] eWin;
    logic [47:0] wMask;
  } vec_t;

  localparam logic [47:0] FULL = 48'hFFFF_FFFF_FFFF;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  vec_t vecs[$];
  vec_t expQ[$];

  instr_queue_if #(.DEPTH(8)) bus();
  instr_queue #(.DEPTH(8)) dut (.iClk(clk), .iRst(rst), .q(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t V(logic flush, logic [15:0] fip, logic wv, logic [15:0] wd,
                             logic wo, logic pop, logic [2:0] pl, logic [3:0] eCount,
                             logic [15:0] eIP, logic eErr, logic eRdy, logic [47:0] eWin,
                             logic [47:0] wMask);
    vec_t v;
    v.flush = flush; v.fip = fip; v.wv = wv; v.wd = wd; v.wo = wo; v.pop = pop; v.pl = pl;
    v.eCount = eCount; v.eIP = eIP; v.eErr = eErr; v.eRdy = eRdy; v.eWin = eWin; v.wMask = wMask;
    return v;
  endfunction

  task automatic chk(string nm, logic [47:0] act, logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    bus.iFlush   = v.flush;
    bus.iFlushIP = v.fip;
    bus.iWrValid = v.wv;
    bus.iWrData  = v.wd;
    bus.iWrOdd   = v.wo;
    bus.iPop     = v.pop;
    bus.iPopLen  = v.pl;
  endtask

  initial begin
    vec_t idle;
    vec_t e;
    checks = 0;
    failures = 0;
    idle = V(0, 16'h0, 0, 16'h0, 0, 0, 3'd0, 4'd0, 16'h0, 0, 1, 48'h0, 48'h0);
    drive(idle);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset count", 48'(bus.oCount), 48'd0);
    chk("reset ip", 48'(bus.oIP), 48'd0);
    chk("reset ready", 48'(bus.oWrReady), 48'd1);
    chk("reset err", 48'(bus.oPopErr), 48'd0);
    chk("reset win", bus.oWin, 48'h0);
    @(negedge clk);
    rst = 1'b0;

    // flush fip wv wd wo pop pl | count ip err rdy win mask
    vecs.push_back(V(0, 16'h0, 0, 16'h0,    0, 0, 3'd0, 4'd0, 16'h0000, 0, 1, 48'h0, FULL));
    vecs.push_back(V(0, 16'h0, 1, 16'h2211, 0, 0, 3'd0, 4'd2, 16'h0000, 0, 1, 48'h2211, FULL));
    vecs.push_back(V(0, 16'h0, 1, 16'h4433, 0, 0, 3'd0, 4'd4, 16'h0000, 0, 1, 48'h44332211, FULL));
    vecs.push_back(V(0, 16'h0, 1, 16'h6655, 0, 0, 3'd0, 4'd6, 16'h0000, 0, 1, 48'h665544332211, FULL));
    vecs.push_back(V(0, 16'h0, 1, 16'h8877, 0, 1, 3'd3, 4'd5, 16'h0003, 0, 1, 48'h118877665544, FULL));
    vecs.push_back(V(1, 16'h0, 1, 16'h1111, 0, 1, 3'd1, 4'd0, 16'h0000, 0, 1, 48'h0, 48'h0));
    vecs.push_back(V(0, 16'h0, 1, 16'h0201, 0, 0, 3'd0, 4'd2, 16'h0000, 0, 1, 48'h0201, 48'hFFFF));
    vecs.push_back(V(0, 16'h0, 1, 16'h0403, 0, 0, 3'd0, 4'd4, 16'h0000, 0, 1, 48'h04030201, 48'hFFFF_FFFF));
    vecs.push_back(V(0, 16'h0, 1, 16'h0605, 0, 0, 3'd0, 4'd6, 16'h0000, 0, 1, 48'h060504030201, FULL));
    vecs.push_back(V(0, 16'h0, 1, 16'h0807, 0, 0, 3'd0, 4'd8, 16'h0000, 0, 0, 48'h060504030201, FULL));
    vecs.push_back(V(0, 16'h0, 1, 16'hEEEE, 0, 0, 3'd0, 4'd8, 16'h0000, 0, 0, 48'h060504030201, FULL));
    vecs.push_back(V(0, 16'h0, 0, 16'h0,    0, 1, 3'd7, 4'd1, 16'h0007, 0, 1, 48'h050403020108, FULL));
    vecs.push_back(V(0, 16'h0, 1, 16'hBBAA, 0, 0, 3'd0, 4'd3, 16'h0007, 0, 1, 48'h050403BBAA08, FULL));
    vecs.push_back(V(0, 16'h0, 1, 16'hDDCC, 0, 0, 3'd0, 4'd5, 16'h0007, 0, 1, 48'h05DDCCBBAA08, FULL));
    vecs.push_back(V(1, 16'hFFFE, 1, 16'h1234, 0, 1, 3'd0, 4'd0, 16'hFFFE, 0, 1, 48'h0, 48'h0));
    vecs.push_back(V(0, 16'h0, 1, 16'h9A00, 1, 0, 3'd0, 4'd1, 16'hFFFE, 0, 1, 48'h9A, 48'hFF));
    vecs.push_back(V(0, 16'h0, 0, 16'h0,    0, 1, 3'd1, 4'd0, 16'hFFFF, 0, 1, 48'h0, 48'h0));
    vecs.push_back(V(0, 16'h0, 1, 16'h5678, 0, 0, 3'd0, 4'd2, 16'hFFFF, 0, 1, 48'h070605DD5678, FULL));
    vecs.push_back(V(0, 16'h0, 0, 16'h0,    0, 1, 3'd4, 4'd2, 16'hFFFF, 1, 1, 48'h070605DD5678, FULL));
    vecs.push_back(V(0, 16'h0, 0, 16'h0,    0, 0, 3'd0, 4'd2, 16'hFFFF, 0, 1, 48'h070605DD5678, FULL));
    vecs.push_back(V(0, 16'h0, 0, 16'h0,    0, 1, 3'd0, 4'd2, 16'hFFFF, 1, 1, 48'h070605DD5678, FULL));
    vecs.push_back(V(0, 16'h0, 0, 16'h0,    0, 0, 3'd0, 4'd2, 16'hFFFF, 0, 1, 48'h070605DD5678, FULL));
    vecs.push_back(V(0, 16'h0, 0, 16'h0,    0, 1, 3'd2, 4'd0, 16'h0001, 0, 1, 48'h0, 48'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      expQ.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = expQ.pop_front();
      chk($sformatf("v%0d count", i), 48'(bus.oCount), 48'(e.eCount));
      chk($sformatf("v%0d ip", i), 48'(bus.oIP), 48'(e.eIP));
      chk($sformatf("v%0d err", i), 48'(bus.oPopErr), 48'(e.eErr));
      chk($sformatf("v%0d ready", i), 48'(bus.oWrReady), 48'(e.eRdy));
      chk($sformatf("v%0d win", i), bus.oWin & e.wMask, e.eWin & e.wMask);
      @(negedge clk);
    end

    // Asynchronous reset between edges must clear state before the next edge.
    drive(V(0, 16'h0, 1, 16'hABCD, 0, 0, 3'd0, 4'd0, 16'h0, 0, 1, 48'h0, 48'h0));
    @(posedge clk);
    #1;
    chk("pre-reset count", 48'(bus.oCount), 48'd2);
    drive(idle);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async count", 48'(bus.oCount), 48'd0);
    chk("async ip", 48'(bus.oIP), 48'd0);
    chk("async win", bus.oWin, 48'h0);
    chk("async ready", 48'(bus.oWrReady), 48'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post-reset count", 48'(bus.oCount), 48'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
